// File: rtl/seq_pkg.sv
// Shared state encoding and framing constants for the 1011 serial frame transmitter.
package seq_pkg;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP} state_t;

    localparam logic [3:0] PREAMBLE_PAT = 4'b1011;
    localparam int         PRE_LEN      = 4;

    // Bits needed to hold a count from 0 up to max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register; shift low holds the word (stuffed-bit cycles).
module seq_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (!reset)
            sr <= '0;
        else if (load)
            sr <= d;
        else if (shift)
            sr <= {sr[W-2:0], 1'b0};
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/seq_frame_tx_1011.sv
// Serial frame transmitter: 1011 preamble, MSB-first payload, GAP idle cycles.
// Define SEQ_TX_STUFF_EN to insert a 0 after every 101 in the payload so 1011 never recurs.
module seq_frame_tx_1011 import seq_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);

    // Worst case every payload bit is followed by a stuffed 0.
    localparam int CW = cnt_w(PRE_LEN + 2*DATA_W + GAP);

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] pay_cnt;
    logic [1:0]    pre_idx;
    logic          accept;
    logic          last_pay;
    logic          stuff;
    logic          piso_shift;
    logic          piso_msb;

    assign accept     = (state == S_IDLE) && data_ready && data_valid;
    assign last_pay   = (pay_cnt == CW'(DATA_W));
    assign pre_idx    = 2'(PRE_LEN - 1) - bit_cnt[1:0];
    assign piso_shift = ((state == S_PREAMBLE) && (bit_cnt == CW'(PRE_LEN))) ||
                        ((state == S_PAYLOAD) && !last_pay && !stuff);

`ifdef SEQ_TX_STUFF_EN
    // Two bits already on the line before the current one; together with out_bit
    // they form the 3-bit history. Cleared whenever the line is idle.
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (!reset || !out_valid)
            hist_q <= 2'b00;
        else
            hist_q <= {hist_q[0], out_bit};
    end

    assign stuff = (state == S_PAYLOAD) && ({hist_q, out_bit} == 3'b101);
`else
    assign stuff = 1'b0;
`endif

    seq_piso #(.W(DATA_W)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (piso_shift),
        .d     (data_in),
        .msb   (piso_msb)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            pay_cnt    <= '0;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    data_ready <= 1'b1;
                    if (accept) begin
                        state      <= S_PREAMBLE;
                        busy       <= 1'b1;
                        data_ready <= 1'b0;
                        out_bit    <= PREAMBLE_PAT[PRE_LEN-1];
                        out_valid  <= 1'b1;
                        bit_cnt    <= CW'(1);
                        pay_cnt    <= '0;
                    end
                end
                S_PREAMBLE: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(PRE_LEN)) begin
                        state   <= S_PAYLOAD;
                        out_bit <= piso_msb;
                        pay_cnt <= CW'(1);
                    end else begin
                        out_bit <= PREAMBLE_PAT[pre_idx];
                    end
                end
                S_PAYLOAD: begin
                    if (last_pay) begin
                        out_bit   <= 1'b0;
                        out_valid <= 1'b0;
                        bit_cnt   <= CW'(1);
                        if (GAP == 0) begin
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            data_ready <= 1'b1;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (stuff) begin
                        out_bit <= 1'b0;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        out_bit    <= piso_msb;
                        pay_cnt    <= pay_cnt + 1'b1;
                        bit_cnt    <= bit_cnt + 1'b1;
                        frame_done <= (pay_cnt == CW'(DATA_W - 1));
                    end
                end
                S_GAP: begin
                    if (bit_cnt == CW'(GAP)) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        data_ready <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frame_tx_1011.sv
// Bench: two transmitters (GAP=2, GAP=0) on shared stimulus, checked against a frame-list model.
module tb_seq_frame_tx_1011;

    localparam int DW = 8;

`ifdef SEQ_TX_STUFF_EN
    localparam logic [31:0] A5_BITS = 32'b1011101000101;
    localparam int          A5_LEN  = 13;
    localparam logic [31:0] B0_BITS = 32'b10111010100000;
    localparam int          B0_LEN  = 14;
`else
    localparam logic [31:0] A5_BITS = 32'b101110100101;
    localparam int          A5_LEN  = 12;
    localparam logic [31:0] B0_BITS = 32'b101110110000;
    localparam int          B0_LEN  = 12;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic [1:0]    rdy, ob, ov, bz, fd;

    seq_frame_tx_1011 #(.DATA_W(DW), .GAP(2)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy[0]), .out_bit(ob[0]), .out_valid(ov[0]), .busy(bz[0]), .frame_done(fd[0])
    );

    seq_frame_tx_1011 #(.DATA_W(DW), .GAP(0)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy[1]), .out_bit(ob[1]), .out_valid(ov[1]), .busy(bz[1]), .frame_done(fd[1])
    );

    always #5 clk = ~clk;

    typedef struct packed { logic b; logic v; logic d; } ent_t;

    ent_t        q [2][$];
    int          gaps [2] = '{2, 0};
    logic [1:0]  e_rdy = 2'b00, e_ob, e_ov, e_bz, e_fd;
    logic [31:0] fbits [2], lbits [2];
    int          flen [2], llen [2], fd_prev [2], fd_last [2], fd_cnt [2];
    int          n_chk = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Whole expected frame as a list of line cycles, derived straight from the framing rules.
    task automatic build(input int i, input logic [DW-1:0] w);
        logic [3:0] pat;
        logic [2:0] h;
        pat = 4'b1011;
        h   = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            q[i].push_back('{pat[k], 1'b1, 1'b0});
            h = {h[1:0], pat[k]};
        end
        for (int k = DW - 1; k >= 0; k--) begin
`ifdef SEQ_TX_STUFF_EN
            if (h == 3'b101) begin
                q[i].push_back('{1'b0, 1'b1, 1'b0});
                h = {h[1:0], 1'b0};
            end
`endif
            q[i].push_back('{w[k], 1'b1, (k == 0)});
            h = {h[1:0], w[k]};
        end
        for (int k = 0; k < gaps[i]; k++)
            q[i].push_back('{1'b0, 1'b0, 1'b0});
    endtask

    task automatic step(input logic r, input logic v, input logic [DW-1:0] d);
        ent_t cur;
        logic pop;
        @(negedge clk);
        reset = r; data_valid = v; data_in = d;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            pop = 1'b0;
            cur = '0;
            if (!r) begin
                q[i].delete();
            end else begin
                if (q[i].size() == 0 && e_rdy[i] && v) build(i, d);
                if (q[i].size() > 0) begin
                    cur = q[i].pop_front();
                    pop = 1'b1;
                end
            end
            e_rdy[i] = r && !pop;
            e_bz[i]  = pop;
            e_ob[i]  = cur.b;
            e_ov[i]  = cur.v;
            e_fd[i]  = cur.d;
            chk($sformatf("rdy%0d", i),  32'(rdy[i]), 32'(e_rdy[i]));
            chk($sformatf("busy%0d", i), 32'(bz[i]),  32'(e_bz[i]));
            chk($sformatf("bit%0d", i),  32'(ob[i]),  32'(e_ob[i]));
            chk($sformatf("ov%0d", i),   32'(ov[i]),  32'(e_ov[i]));
            chk($sformatf("fd%0d", i),   32'(fd[i]),  32'(e_fd[i]));
            if (ov[i] !== 1'b1) begin
                fbits[i] = '0;
                flen[i]  = 0;
            end else begin
                fbits[i] = {fbits[i][30:0], ob[i]};
                flen[i]++;
            end
            if (fd[i] === 1'b1) begin
                lbits[i]   = fbits[i];
                llen[i]    = flen[i];
                fd_prev[i] = fd_last[i];
                fd_last[i] = cyc;
                fd_cnt[i]++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, DW'($urandom));
    endtask

    int n_fd;

    initial begin
        for (int i = 0; i < 2; i++) begin
            fbits[i] = '0; lbits[i] = '0; flen[i] = 0; llen[i] = 0;
            fd_prev[i] = 0; fd_last[i] = 0; fd_cnt[i] = 0;
        end

        repeat (3) step(1'b0, 1'b1, DW'($urandom));
        chk("rst_rdy",  32'(rdy), 32'd0);
        chk("rst_ov",   32'(ov),  32'd0);
        chk("rst_bit",  32'(ob),  32'd0);
        chk("rst_busy", 32'(bz),  32'd0);
        idle(1);
        chk("rel_rdy", 32'(rdy), 32'd3);

        step(1'b1, 1'b1, 8'hA5);
        idle(20);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("a5_len%0d", i),  32'(llen[i]), 32'(A5_LEN));
            chk($sformatf("a5_bits%0d", i), lbits[i],     A5_BITS);
        end

        step(1'b1, 1'b1, 8'hB0);
        idle(20);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("b0_len%0d", i),  32'(llen[i]), 32'(B0_LEN));
            chk($sformatf("b0_bits%0d", i), lbits[i],     B0_BITS);
        end

        repeat (40) step(1'b1, 1'b1, 8'h3C);
        chk("b2b_per0", 32'(fd_last[0] - fd_prev[0]), 32'd15);
        chk("b2b_per1", 32'(fd_last[1] - fd_prev[1]), 32'd13);
        repeat (40) step(1'b1, 1'b1, 8'hFF);
        chk("ff_per0", 32'(fd_last[0] - fd_prev[0]), 32'd15);
        chk("ff_per1", 32'(fd_last[1] - fd_prev[1]), 32'd13);
        idle(20);

        n_fd = fd_cnt[0];
        step(1'b1, 1'b1, 8'h5A);
        idle(9);
        step(1'b0, 1'b0, DW'($urandom));
        chk("midrst_ov", 32'(ov), 32'd0);
        idle(3);
        chk("midrst_nofd", 32'(fd_cnt[0] - n_fd), 32'd0);
        step(1'b1, 1'b1, 8'hA5);
        idle(20);
        chk("post_rst_bits", lbits[0], A5_BITS);

        for (int k = 0; k < 2000; k++)
            step(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 1)), DW'($urandom));
        idle(25);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx_1011.md
Name: seq_frame_tx_1011

Overview:
Serial frame transmitter; it is the sending end of the 1011 sequence-detect link.
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Emits one bit per clock: sync preamble 1,0,1,1, then payload MSB-first, then GAP idle-zero cycles.
- Drives the serial line feeding the team's 1011 detector/receiver blocks.

Parameters:
DATA_W, 8, payload width in bits (>=2)
GAP, 2, idle cycles (out_bit=0, out_valid=0) after each frame (>=0)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous reset, active-low (0 = reset)
data_in  input  DATA_W  payload word, sampled on accept
data_valid  input  1  payload word available
data_ready  output  1  transmitter can accept a word
out_bit  output  1  serial line bit, registered
out_valid  output  1  out_bit carries preamble/payload/stuff bit this cycle
busy  output  1  high in any state except IDLE
frame_done  output  1  one-cycle pulse coincident with last payload bit

Behaviour:
- Reset (reset=0 at posedge): state IDLE, out_bit=0, out_valid=0, frame_done=0, busy=0, data_ready=0 while reset held; data_ready=1 first cycle after release.
- States: IDLE -> PREAMBLE -> PAYLOAD -> GAP -> IDLE; skip GAP when GAP=0.
- IDLE: data_ready=1, out_bit=0, out_valid=0. Accept when data_valid&&data_ready at edge N; data_in latched into shift register; data_in changes afterwards are ignored.
- PREAMBLE: cycles N+1..N+4 present out_bit 1,0,1,1 with out_valid=1.
- PAYLOAD: next DATA_W cycles present latched word MSB-first, out_valid=1. frame_done=1 only in the cycle presenting bit 0.
- GAP: GAP cycles with out_bit=0, out_valid=0, data_ready=0; then IDLE.
- data_ready=1 only in IDLE: minimum accept-to-accept period = 5+DATA_W+GAP cycles (no stuffing).
- All outputs registered; no combinational path from data_valid to data_ready.
- Reset mid-frame: next edge forces IDLE, out_valid=0, no frame_done; the partial frame is dropped.
- Bit counter sized for the longest frame including stuffed bits; no wrap within a frame.

Optional Feature:
SEQ_TX_STUFF_EN:
- Defined: 3-bit history of emitted line bits, including preamble and stuffed bits, reset to 000 in IDLE. In PAYLOAD, when history==101 and payload bits remain, insert one stuffed 0 (out_valid=1) before the next payload bit.
- Effect: 1011 never occurs after the preamble, and the receiver can remove stuffing by dropping the 0 after every 101.
- Frame length becomes variable; frame_done still marks the last payload bit.
- Undefined: no history logic; frame length fixed at 4+DATA_W.

Decomposition:
- Package seq_pkg: state enum (IDLE, PREAMBLE, PAYLOAD, GAP), PREAMBLE_PAT=4'b1011, PRE_LEN=4, counter-width function.
- Sub-module seq_piso: parallel-load, MSB-first shift register with a load and hold/shift enable. Hold is used for stuffed-bit cycles.
- FSM, counters and stuffing logic stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with data_valid=1 -> out_valid=0, out_bit=0, data_ready=0, busy=0; data_ready=1 the cycle after release.
- Single frame (DATA_W=8, GAP=2): accept 0xA5 at edge 0 -> cycles 1-12 out_bit 1,0,1,1,1,0,1,0,0,1,0,1; frame_done only at cycle 12; cycles 13-14 out_valid=0; data_ready=1 at cycle 15.
- Back-to-back: data_valid held with 0x3C, then 0xFF -> second preamble starts cycle 16; 0xFF never appears mid-frame if data_in changes while busy.
- Reset mid-payload: reset=0 during payload bit 3 -> next cycle IDLE, out_valid=0, no frame_done; the next frame is clean.
- GAP=0: two consecutive 0x00 frames -> exactly one out_valid=0 IDLE cycle between frames.
- SEQ_TX_STUFF_EN with 0xB0 -> line bits 1,0,1,1, 1,0,1,0*,1,0*,0,0,0,0 (* = stuffed); frame_done on the 14th bit. Without the macro: 12 bits, frame_done on the 12th.
